// File: rtl/model_issue_ctrl.sv
// model_issue_ctrl: issues stimulus instructions to a DUT and a golden
// reference model (GRM) in lockstep, buffers GRM results until the DUT
// answers, and presents aligned DUT/GRM pairs for checking.
//
// Handshake: an instruction transfers on a cycle where dut_in_valid and
// dut_in_ready are both high; stim_ready and grm_in_valid mirror that
// transfer. Result pairing is zero-latency: cmp_valid is asserted in the
// same cycle dut_out_valid rises, provided a GRM result is buffered or
// arriving in that cycle.
module model_issue_ctrl #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                       g_clk,
  input  logic                       g_resetn,
  // stimulus side
  input  logic                       stim_valid,
  output logic                       stim_ready,
  input  logic [31:0]                stim_insn_enc,
  input  logic [31:0]                stim_rs1,
  input  logic                       drain_req,
  // issue to DUT / GRM
  output logic                       dut_in_valid,
  input  logic                       dut_in_ready,
  output logic [31:0]                dut_insn_enc,
  output logic [31:0]                dut_rs1,
  output logic                       grm_in_valid,
  // GRM results
  input  logic                       grm_out_valid,
  input  logic [2:0]                 grm_result,
  input  logic                       grm_rd_wen,
  input  logic [4:0]                 grm_rd_addr,
  input  logic [31:0]                grm_rd_data,
  // DUT results
  input  logic                       dut_out_valid,
  // comparison side
  output logic                       cmp_valid,
  output logic [40:0]                cmp_grm_pkt,
  // status / debug
  output logic [$clog2(DEPTH):0]     outstanding,
  output logic [1:0]                 state,
  output logic                       drain_done,
  output logic [2:0]                 err_flags
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned PKT_W = 41;

  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     out_q, out_d;
  logic [CW-1:0]     fcnt_q, fcnt_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PKT_W-1:0]  mem_q [DEPTH];
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [2:0]        err_q, err_d;
  logic              done_q, done_d;

  logic [PKT_W-1:0]  grm_pkt;
  logic              fifo_empty;
  logic              fifo_full;
  logic              issue_ok;
  logic              issue;
  logic              bypass;
  logic              pop;
  logic              push_req;
  logic              push;
  logic              overrun;
  logic              spurious;
  logic              tmo_hit;

  // GRM result packed in the order the checker expects
  assign grm_pkt    = {grm_result, grm_rd_wen, grm_rd_addr, grm_rd_data};
  assign fifo_empty = (fcnt_q == '0);
  assign fifo_full  = (fcnt_q == DEPTH_C);

  // Issue only while running and while the DUT has room for more work
  assign issue_ok     = stim_valid && (state_q == ST_RUN) && (out_q < DEPTH_C);
  assign issue        = issue_ok && dut_in_ready;
  assign dut_in_valid = issue_ok;
  assign stim_ready   = issue;
  assign grm_in_valid = issue;
  assign dut_insn_enc = stim_insn_enc;
  assign dut_rs1      = stim_rs1;

  // A DUT result pairs with the oldest buffered GRM result, or with the
  // GRM result arriving this very cycle when nothing is buffered.
  assign cmp_valid   = dut_out_valid && (!fifo_empty || grm_out_valid);
  assign cmp_grm_pkt = fifo_empty ? grm_pkt : mem_q[rd_ptr_q];

  // The bypassed GRM result is consumed directly and never enters the FIFO
  assign bypass   = fifo_empty && grm_out_valid && dut_out_valid;
  assign pop      = cmp_valid && !fifo_empty;
  assign push_req = grm_out_valid && !bypass;
  assign push     = push_req && (!fifo_full || pop);
  assign overrun  = push_req && fifo_full && !pop;
  assign spurious = dut_out_valid && fifo_empty && !grm_out_valid;

  // FIFO pointer and occupancy bookkeeping
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    fcnt_d   = fcnt_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      fcnt_d = fcnt_q + 1'b1;
    end else if (pop && !push) begin
      fcnt_d = fcnt_q - 1'b1;
    end
  end

  // Outstanding count: issues in, DUT responses out; a response with
  // nothing outstanding is not allowed to wrap the counter.
  always_comb begin
    out_d = out_q;
    if (issue && !cmp_valid) begin
      out_d = out_q + 1'b1;
    end else if (cmp_valid && !issue && (out_q != '0)) begin
      out_d = out_q - 1'b1;
    end
  end

  // Timeout counter: idle or answering DUT clears it, otherwise it
  // counts up and holds once it reaches the limit.
  always_comb begin
    tmo_d = tmo_q;
    if ((out_q == '0) || dut_out_valid) begin
      tmo_d = '0;
    end else if (tmo_q != TIMEOUT_C) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  assign tmo_hit = (tmo_d == TIMEOUT_C);

  // Sticky error accumulation {timeout, spurious, overrun}
  always_comb begin
    err_d = err_q | {tmo_hit, spurious, overrun};
  end

  // Controller next-state: errors win over drain handling; HALT is terminal
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (err_q != 3'b000) begin
      state_d = ST_HALT;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (drain_req) begin
            state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if ((out_q == '0) && fifo_empty) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
        ST_DONE: begin
          if (!drain_req) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // Control and status registers with synchronous active-low reset
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q  <= ST_RUN;
      out_q    <= '0;
      fcnt_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      tmo_q    <= '0;
      err_q    <= 3'b000;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      fcnt_q   <= fcnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  // GRM result storage; contents are don't-care while the FIFO is empty
  always_ff @(posedge g_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= grm_pkt;
    end
  end

  assign outstanding = out_q;
  assign state       = state_q;
  assign drain_done  = done_q;
  assign err_flags   = err_q;

endmodule
